// File: rtl/dca_matrix_lsu_inst_sched.sv
// Instruction scheduler for the matrix LSU.
// A small instruction queue feeds a three-state decode FSM. The FSM issues
// READ/WRITE instructions to per-channel load/store engines. It tracks the
// outstanding transfers per channel and per direction, and it orders FENCEs
// behind every transfer still in flight.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. Valid never waits on ready. The scheduler keeps rd_/wr_issue_valid
// asserted while it is blocked only by ready. It withdraws valid when a
// limit or hazard appears, when enable is low, or when clear is high.
// inst_wvalid/inst_wready follow the same rule. A beat also needs enable.
module dca_matrix_lsu_inst_sched #(
  parameter int BW_INST          = 64,
  parameter int INST_FIFO_DEPTH  = 4,
  parameter int NUM_CH           = 2,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int ALLOW_RW_OVERLAP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic               inst_wvalid,
  input  logic [BW_INST-1:0] inst_wdata,
  output logic               inst_wready,
  output logic [NUM_CH-1:0]  rd_issue_valid,
  input  logic [NUM_CH-1:0]  rd_issue_ready,
  output logic [NUM_CH-1:0]  wr_issue_valid,
  input  logic [NUM_CH-1:0]  wr_issue_ready,
  output logic [BW_INST-1:0] issue_inst,
  input  logic [NUM_CH-1:0]  rd_done,
  input  logic [NUM_CH-1:0]  wr_done,
  output logic               inst_decode_finish,
  output logic               inst_execute_finish,
  output logic               inst_error,
  output logic               busy,
  output logic               inst_is_write,
  output logic [1:0]         state_dbg
);

  localparam int BW_CH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW    = 4;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_FENCE = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic               head_valid;
  logic [BW_INST-1:0] head_inst;
  logic               q_nonempty;

  logic [NUM_CH-1:0][CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [NUM_CH-1:0][CW-1:0] wr_cnt_q, wr_cnt_d;
  logic                      is_write_q, is_write_d;
  logic                      exec_fin_q, exec_fin_d;

  logic [1:0]          opcode;
  logic [BW_CH-1:0]    ch;
  logic                ch_ok;
  logic [NUM_CH-1:0]   ch_oh;
  logic [CW-1:0]       sel_rd_cnt, sel_wr_cnt;
  logic                any_cnt;
  logic                rd_ok, wr_ok;

  // Instruction source: a real queue, or a direct pass-through of the input.
  generate
    if (INST_FIFO_DEPTH == 0) begin : g_bypass
      assign head_valid  = inst_wvalid;
      assign head_inst   = inst_wdata;
      assign q_nonempty  = 1'b0;
      assign inst_wready = inst_decode_finish;
    end else begin : g_fifo
      localparam int PW = (INST_FIFO_DEPTH > 1) ? $clog2(INST_FIFO_DEPTH) : 1;
      localparam int NW = $clog2(INST_FIFO_DEPTH + 1);

      logic [BW_INST-1:0] mem_q [INST_FIFO_DEPTH];
      logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
      logic [NW-1:0]      cnt_q, cnt_d;
      logic               push, pop;

      assign inst_wready = (cnt_q != NW'(INST_FIFO_DEPTH));
      assign push        = inst_wvalid & inst_wready & enable & ~clear;
      assign pop         = inst_decode_finish & ~clear;
      assign head_valid  = (cnt_q != '0);
      assign q_nonempty  = head_valid;
      assign head_inst   = mem_q[rd_ptr_q];

      // Pointer and occupancy bookkeeping; clear wins over push and pop.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(INST_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(INST_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        if (push && !pop)      cnt_d = cnt_q + NW'(1);
        else if (!push && pop) cnt_d = cnt_q - NW'(1);
        if (clear) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
        end
      end

      // Queue control registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
        end
      end

      // Queue storage; contents are meaningless while the entry is not counted.
      always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= inst_wdata;
      end
    end
  endgenerate

  assign opcode = head_inst[1:0];
  assign ch     = head_inst[2+BW_CH-1:2];
  assign ch_ok  = (int'(ch) < NUM_CH);

  // Channel one-hot and the selected channel's counters.
  always_comb begin
    ch_oh      = '0;
    sel_rd_cnt = '0;
    sel_wr_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_oh[c] = (int'(ch) == c);
      if (ch_oh[c]) begin
        sel_rd_cnt = rd_cnt_q[c];
        sel_wr_cnt = wr_cnt_q[c];
      end
    end
  end

  assign any_cnt = (|rd_cnt_q) | (|wr_cnt_q);
  assign rd_ok   = (sel_rd_cnt < CW'(MAX_OUTSTANDING)) &&
                   ((ALLOW_RW_OVERLAP != 0) || (sel_wr_cnt == '0));
  assign wr_ok   = (sel_wr_cnt < CW'(MAX_OUTSTANDING)) &&
                   ((ALLOW_RW_OVERLAP != 0) || (sel_rd_cnt == '0));

  // Decode FSM: next state, issue strobes, and the finish/error pulses.
  always_comb begin
    state_d            = state_q;
    rd_issue_valid     = '0;
    wr_issue_valid     = '0;
    inst_error         = 1'b0;
    inst_decode_finish = 1'b0;
    is_write_d         = is_write_q;
    case (state_q)
      IDLE: begin
        if (enable && head_valid) state_d = DECODE;
      end
      DECODE: begin
        if (enable && !clear) begin
          case (opcode)
            OP_NOP:   state_d = DONE;
            OP_FENCE: if (!any_cnt) state_d = DONE;
            default: begin
              if (!ch_ok) begin
                inst_error = 1'b1;
                state_d    = DONE;
              end else if (opcode == OP_READ) begin
                if (rd_ok) begin
                  rd_issue_valid = ch_oh;
                  if (|(ch_oh & rd_issue_ready)) begin
                    state_d    = DONE;
                    is_write_d = 1'b0;
                  end
                end
              end else begin
                if (wr_ok) begin
                  wr_issue_valid = ch_oh;
                  if (|(ch_oh & wr_issue_ready)) begin
                    state_d    = DONE;
                    is_write_d = (opcode == OP_WRITE);
                  end
                end
              end
            end
          endcase
        end
      end
      DONE: begin
        if (enable) begin
          inst_decode_finish = 1'b1;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // Outstanding counters: +1 on an issue handshake, -1 on a done pulse (a pulse at zero is ignored).
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      case ({rd_issue_valid[c] & rd_issue_ready[c], rd_done[c] & (rd_cnt_q[c] != '0)})
        2'b10:   rd_cnt_d[c] = rd_cnt_q[c] + CW'(1);
        2'b01:   rd_cnt_d[c] = rd_cnt_q[c] - CW'(1);
        default: rd_cnt_d[c] = rd_cnt_q[c];
      endcase
      case ({wr_issue_valid[c] & wr_issue_ready[c], wr_done[c] & (wr_cnt_q[c] != '0)})
        2'b10:   wr_cnt_d[c] = wr_cnt_q[c] + CW'(1);
        2'b01:   wr_cnt_d[c] = wr_cnt_q[c] - CW'(1);
        default: wr_cnt_d[c] = wr_cnt_q[c];
      endcase
    end
    if (clear) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end
  end

  // Any engine completion shows up on inst_execute_finish one cycle later.
  always_comb begin
    exec_fin_d = |(rd_done | wr_done);
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      is_write_q <= 1'b0;
      exec_fin_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      is_write_q <= is_write_d;
      exec_fin_q <= exec_fin_d;
    end
  end

  assign issue_inst          = head_inst;
  assign inst_is_write       = is_write_q;
  assign inst_execute_finish = exec_fin_q;
  assign busy                = q_nonempty | (state_q != IDLE) | any_cnt;
  assign state_dbg           = state_q;

endmodule

// File: tb/tb_dca_matrix_lsu_inst_sched.sv
// Bench for dca_matrix_lsu_inst_sched: 3 channels, so the channel field is
// 2 bits wide. Read/write overlap is disabled, the queue depth is 4 and the
// outstanding limit is 4.
module tb_dca_matrix_lsu_inst_sched;

  localparam int BW    = 64;
  localparam int NCH   = 3;
  localparam int MAXO  = 4;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           clear;
  logic           enable;
  logic           inst_wvalid;
  logic [BW-1:0]  inst_wdata;
  logic           inst_wready;
  logic [NCH-1:0] rd_issue_valid, rd_issue_ready, wr_issue_valid, wr_issue_ready;
  logic [BW-1:0]  issue_inst;
  logic [NCH-1:0] rd_done, wr_done;
  logic           inst_decode_finish, inst_execute_finish, inst_error, busy, inst_is_write;
  logic [1:0]     state_dbg;

  dca_matrix_lsu_inst_sched #(
    .BW_INST(BW), .INST_FIFO_DEPTH(DEPTH), .NUM_CH(NCH),
    .MAX_OUTSTANDING(MAXO), .ALLOW_RW_OVERLAP(0)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable),
    .inst_wvalid(inst_wvalid), .inst_wdata(inst_wdata), .inst_wready(inst_wready),
    .rd_issue_valid(rd_issue_valid), .rd_issue_ready(rd_issue_ready),
    .wr_issue_valid(wr_issue_valid), .wr_issue_ready(wr_issue_ready),
    .issue_inst(issue_inst), .rd_done(rd_done), .wr_done(wr_done),
    .inst_decode_finish(inst_decode_finish), .inst_execute_finish(inst_execute_finish),
    .inst_error(inst_error), .busy(busy), .inst_is_write(inst_is_write),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue contents, the phase of the head instruction, and outstanding counts.
  logic [BW-1:0] mq[$];
  int            ph;        // 0 waiting, 1 being decoded, 2 finishing
  int            rc[NCH];
  int            wc[NCH];
  logic          m_exec, m_isw;

  // Observed events, recorded from DUT outputs for the directed checks.
  int            rd_hs[NCH];
  int            wr_hs[NCH];
  int            rd_v_cycles = 0;
  logic [NCH-1:0] last_rd_v = '0;
  int            last_rd_hs_cyc = -1, last_wr_hs_cyc = -1;
  int            fin_cnt = 0, last_fin_cyc = -1, err_cnt = 0;

  function automatic bit all_zero();
    for (int c = 0; c < NCH; c++) if (rc[c] != 0 || wc[c] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int hs_total();
    int s = 0;
    for (int c = 0; c < NCH; c++) s += rd_hs[c] + wr_hs[c];
    return s;
  endfunction

  initial begin
    ph = 0; m_exec = 1'b0; m_isw = 1'b0;
    for (int c = 0; c < NCH; c++) begin rc[c] = 0; wc[c] = 0; rd_hs[c] = 0; wr_hs[c] = 0; end
  end

  // ---------------- compare process (every cycle, on the falling edge) ----------------
  always @(negedge clk) begin : mon
    logic [NCH-1:0] e_rdv, e_wrv;
    logic e_err, e_fin, e_busy, e_wrdy, adv, hs, push;
    logic [1:0] op;
    logic [BW-1:0] h;
    int ch, same, other;
    e_rdv = '0; e_wrv = '0; e_err = 1'b0; adv = 1'b0; hs = 1'b0; op = 2'd0; ch = 0; h = '0;
    if (rst) begin
      mq.delete(); ph = 0; m_exec = 1'b0; m_isw = 1'b0;
      for (int c = 0; c < NCH; c++) begin rc[c] = 0; wc[c] = 0; end
      chk("rst_rd_valid", rd_issue_valid, '0);
      chk("rst_wr_valid", wr_issue_valid, '0);
      chk("rst_finish",   {inst_decode_finish, inst_execute_finish}, 2'b00);
      chk("rst_error",    inst_error, 1'b0);
      chk("rst_busy",     busy, 1'b0);
      chk("rst_is_write", inst_is_write, 1'b0);
      chk("rst_wready",   inst_wready, 1'b1);
    end else begin
      if (ph == 1 && enable && !clear) begin
        h = mq[0]; op = h[1:0]; ch = int'(h[3:2]);
        if (op == 2'd0) adv = 1'b1;
        else if (op == 2'd3) adv = all_zero();
        else if (ch >= NCH) begin e_err = 1'b1; adv = 1'b1; end
        else begin
          same  = (op == 2'd1) ? rc[ch] : wc[ch];
          other = (op == 2'd1) ? wc[ch] : rc[ch];
          if (same < MAXO && other == 0) begin
            if (op == 2'd1) begin e_rdv[ch] = 1'b1; hs = rd_issue_ready[ch]; end
            else            begin e_wrv[ch] = 1'b1; hs = wr_issue_ready[ch]; end
            adv = hs;
          end
        end
      end
      e_fin  = (ph == 2) && enable;
      e_wrdy = (mq.size() < DEPTH);
      e_busy = (mq.size() > 0) || (ph != 0) || !all_zero();

      chk("rd_issue_valid", rd_issue_valid, e_rdv);
      chk("wr_issue_valid", wr_issue_valid, e_wrv);
      chk("inst_error", inst_error, e_err);
      chk("decode_finish", inst_decode_finish, e_fin);
      chk("busy", busy, e_busy);
      chk("inst_wready", inst_wready, e_wrdy);
      chk("execute_finish", inst_execute_finish, m_exec);
      chk("inst_is_write", inst_is_write, m_isw);
      if (ph == 1) chk("issue_inst", issue_inst, mq[0]);

      if (|rd_issue_valid) begin rd_v_cycles++; last_rd_v = rd_issue_valid; end
      for (int c = 0; c < NCH; c++) begin
        if (rd_issue_valid[c] && rd_issue_ready[c]) begin rd_hs[c]++; last_rd_hs_cyc = cyc; end
        if (wr_issue_valid[c] && wr_issue_ready[c]) begin wr_hs[c]++; last_wr_hs_cyc = cyc; end
      end
      if (inst_decode_finish) begin fin_cnt++; last_fin_cyc = cyc; end
      if (inst_error) err_cnt++;

      // advance the model to the state after the coming rising edge
      m_exec = |(rd_done | wr_done);
      if (clear) begin
        mq.delete(); ph = 0;
        for (int c = 0; c < NCH; c++) begin rc[c] = 0; wc[c] = 0; end
      end else begin
        for (int c = 0; c < NCH; c++) begin
          rc[c] = rc[c] + ((e_rdv[c] && rd_issue_ready[c]) ? 1 : 0) - ((rd_done[c] && rc[c] > 0) ? 1 : 0);
          wc[c] = wc[c] + ((e_wrv[c] && wr_issue_ready[c]) ? 1 : 0) - ((wr_done[c] && wc[c] > 0) ? 1 : 0);
        end
        if (hs) m_isw = (op == 2'd2);
        push = inst_wvalid && e_wrdy && enable;
        case (ph)
          0: if (enable && mq.size() > 0) ph = 1;
          1: if (adv) ph = 2;
          default: if (enable) ph = 0;
        endcase
        if (e_fin) void'(mq.pop_front());
        if (push) mq.push_back(inst_wdata);
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  // Present one instruction until it is accepted; returns the accept cycle.
  task automatic send(input logic [BW-1:0] w, output int acc);
    acc = -1;
    inst_wvalid = 1'b1;
    inst_wdata  = w;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (inst_wready && enable) begin
        step();
        acc = cyc - 1;
        inst_wvalid = 1'b0;
        return;
      end
      step();
    end
    inst_wvalid = 1'b0;
    total++; bad++;
    $display("FAIL send_timeout: got no acceptance expected acceptance of 0x%0h", w);
  endtask

  task automatic pulse_done(input bit is_wr, input int c, output int d);
    if (is_wr) wr_done[c] = 1'b1; else rd_done[c] = 1'b1;
    d = cyc;
    step();
    rd_done = '0;
    wr_done = '0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : drive
    int a, d, d1, d2, h0, r0, t0, f0, e0;
    rst = 1'b1; clear = 1'b0; enable = 1'b1;
    inst_wvalid = 1'b0; inst_wdata = '0;
    rd_issue_ready = '1; wr_issue_ready = '1;
    rd_done = '0; wr_done = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_wready", inst_wready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_state", state_dbg, 2'd0);
    step();
    rst = 1'b0;
    wait_cycles(2);

    // READ ch1: one-cycle rd_issue_valid=3'b010, finish three cycles after accept
    r0 = rd_v_cycles; h0 = rd_hs[1];
    send(64'h5, a);
    wait_cycles(6);
    chk("t1_valid_cycles", rd_v_cycles - r0, 1);
    chk("t1_valid_bits", last_rd_v, 3'b010);
    chk("t1_handshakes", rd_hs[1] - h0, 1);
    chk("t1_latency", last_fin_cyc - a, 3);
    chk("t1_model_cnt", rc[1], 1);
    pulse_done(1'b0, 1, d);
    wait_cycles(2);
    @(negedge clk); chk("t1_idle_busy", busy, 1'b0); step();

    // five READs ch0: four issue, fifth waits for a completion
    h0 = rd_hs[0];
    for (int i = 0; i < 5; i++) send(64'h1, a);
    wait_cycles(15);
    chk("t2_issued4", rd_hs[0] - h0, 4);
    @(negedge clk);
    chk("t2_busy", busy, 1'b1);
    chk("t2_state_decode", state_dbg, 2'd1);
    step();
    pulse_done(1'b0, 0, d);
    wait_cycles(3);
    chk("t2_fifth_cycle", last_rd_hs_cyc, d + 1);
    chk("t2_issued5", rd_hs[0] - h0, 5);
    for (int i = 0; i < 5; i++) pulse_done(1'b0, 0, d);   // last pulse lands on a zero count
    wait_cycles(2);
    @(negedge clk); chk("t2_drained_busy", busy, 1'b0); step();

    // issue handshake and completion in the same cycle leave the count unchanged
    send(64'h1, a);
    wait_cycles(5);
    rd_issue_ready = '0;
    send(64'h1, a);
    wait_cycles(3);
    rd_issue_ready = '1; rd_done[0] = 1'b1;
    step();
    rd_done = '0;
    wait_cycles(3);
    chk("t2b_model_cnt", rc[0], 1);
    @(negedge clk); chk("t2b_busy_held", busy, 1'b1); step();
    pulse_done(1'b0, 0, d);
    @(negedge clk); chk("t2b_busy_after", busy, 1'b0); step();

    // READ ch0 then WRITE ch0 without overlap: write waits for rd_done
    h0 = wr_hs[0];
    send(64'h1, a);
    send(64'h2, a);
    wait_cycles(8);
    chk("t3_write_blocked", wr_hs[0] - h0, 0);
    pulse_done(1'b0, 0, d);
    wait_cycles(4);
    chk("t3_write_cycle", last_wr_hs_cyc, d + 1);
    @(negedge clk); chk("t3_is_write", inst_is_write, 1'b1); step();
    pulse_done(1'b1, 0, d);

    // FENCE behind two outstanding writes
    send(64'h2, a);
    send(64'h2, a);
    wait_cycles(8);
    send(64'h3, a);
    wait_cycles(8);
    f0 = fin_cnt;
    pulse_done(1'b1, 0, d1);
    wait_cycles(5);
    chk("t4_fence_held", fin_cnt - f0, 0);
    pulse_done(1'b1, 0, d2);
    wait_cycles(5);
    chk("t4_fence_done", fin_cnt - f0, 1);
    chk("t4_fence_cycle", last_fin_cyc, d2 + 2);

    // NOP: finish without any issue
    t0 = hs_total();
    send(64'h0, a);
    wait_cycles(6);
    chk("t4_nop_latency", last_fin_cyc - a, 3);
    chk("t4_nop_no_issue", hs_total() - t0, 0);

    // channel 3 on a 3-channel build: error pulse, no issue
    e0 = err_cnt; t0 = hs_total();
    send(64'hD, a);
    wait_cycles(6);
    chk("t5_err_rd", err_cnt - e0, 1);
    chk("t5_err_latency", last_fin_cyc - a, 3);
    send(64'hE, a);
    wait_cycles(6);
    chk("t5_err_wr", err_cnt - e0, 2);
    chk("t5_no_issue", hs_total() - t0, 0);
    @(negedge clk); chk("t5_busy", busy, 1'b0); step();

    // fill the queue, stall with enable low, then clear everything
    send(64'h9, a);               // READ ch2 left outstanding
    wait_cycles(5);
    rd_issue_ready = '0;
    for (int i = 0; i < 4; i++) send(64'h1, a);
    wait_cycles(2);
    @(negedge clk);
    chk("t6_full_wready", inst_wready, 1'b0);
    chk("t6_valid_held", rd_issue_valid, 3'b001);
    step();
    enable = 1'b0;
    wait_cycles(3);
    @(negedge clk); chk("t6_enable_low", rd_issue_valid, 3'b000); step();
    enable = 1'b1;
    clear = 1'b1; rd_done[2] = 1'b1; inst_wvalid = 1'b1; inst_wdata = 64'h1;
    step();
    clear = 1'b0; rd_done = '0; inst_wvalid = 1'b0;
    @(negedge clk);
    chk("t6_clear_busy", busy, 1'b0);
    chk("t6_clear_wready", inst_wready, 1'b1);
    step();
    rd_issue_ready = '1;

    // reset in the middle of a blocked issue
    rd_issue_ready = '0;
    h0 = rd_hs[2];
    send(64'h9, a);
    wait_cycles(2);
    @(negedge clk); chk("t7_pre_valid", rd_issue_valid, 3'b100); step();
    rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_valid", rd_issue_valid, 3'b000);
    chk("t7_rst_busy", busy, 1'b0);
    step();
    rd_issue_ready = '1;
    step();
    rst = 1'b0;
    wait_cycles(3);
    chk("t7_no_issue", rd_hs[2] - h0, 0);
    @(negedge clk); chk("t7_busy_after", busy, 1'b0); step();
    send(64'h9, a);
    wait_cycles(6);
    chk("t7_reissue_latency", last_fin_cyc - a, 3);
    chk("t7_reissue", rd_hs[2] - h0, 1);
    pulse_done(1'b0, 2, d);
    wait_cycles(2);
    @(negedge clk); chk("t7_final_busy", busy, 1'b0); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #300000;
    $display("FAIL global_timeout: got no completion expected completion");
    $fatal(1, "time limit");
  end

endmodule
